dcm_phase_shift_interface: RTL and testbench

//  Drives the variable phase-shift port (PSEN/PSINCDEC/PSDONE) of a Spartan-6 DCM_SP.

---
 rtl/dcm_phase_shift_interface_pkg.sv | 30 +++
 rtl/dcm_phase_shift_interface.sv | 149 ++++++++++++++
 tb/tb_dcm_phase_shift_interface.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/dcm_phase_shift_interface_pkg.sv
// Shared types and constants for the DCM_SP variable phase-shift controller.
// Phases are 9-bit two's complement, symmetric range [-255, +255].
package dcm_phase_shift_interface_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_STEP  = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    typedef logic signed [8:0] phase_t;

    localparam int PHASE_MAX        = 255;
    localparam int PHASE_MIN        = -255;
    localparam int STATUS_PSOVF_BIT = 0;

    // Only -256 can fall outside the range; it folds onto -255.
    function automatic phase_t clamp_phase(input phase_t v);
        phase_t r;
        r = v;
        if (v < phase_t'(PHASE_MIN)) begin
            r = phase_t'(PHASE_MIN);
        end else if (v > phase_t'(PHASE_MAX)) begin
            r = phase_t'(PHASE_MAX);
        end
        return r;
    endfunction

endpackage

// File: rtl/dcm_phase_shift_interface.sv
// Steps a Spartan-6 DCM_SP phase one inc/dec at a time until it matches a loaded target.
// clk_i is the DCM PSCLK; at most one step is outstanding at any time.
module dcm_phase_shift_interface
    import dcm_phase_shift_interface_pkg::*;
#(
    parameter int PSDONE_TIMEOUT = 1023
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [8:0] default_value_i,
    input  logic [8:0] value_i,
    input  logic       load_i,
    output logic [8:0] value_o,
    output logic       done_o,
    output logic       dcm_psen_o,
    output logic       dcm_psincdec_o,
    input  logic [7:0] dcm_status_i,
    input  logic       dcm_psdone_i,
    output logic [1:0] state_o
);

    localparam int TW = (PSDONE_TIMEOUT > 1) ? $clog2(PSDONE_TIMEOUT) : 1;

    // Handshake: dcm_psen_o is a one-cycle request; dcm_psdone_i is a one-cycle
    // acknowledge accepted only in ST_WAIT. No new request until acknowledge or timeout.

    logic [1:0] rst_sync_q;
    logic       rst_n;

    // Asynchronous assert, synchronous release.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    state_e        state_q, state_d;
    phase_t        cur_q, cur_d;
    phase_t        target_q, target_d;
    logic          done_q, done_d;
    logic          psen_q, psen_d;
    logic          incdec_q, incdec_d;
    logic [TW-1:0] tmo_q, tmo_d;
    phase_t        load_phase;
    logic          unused_status;

    assign load_phase    = clamp_phase(phase_t'(value_i));
    assign unused_status = ^dcm_status_i[7:1];

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        target_d = target_q;
        done_d   = done_q;
        psen_d   = 1'b0;
        incdec_d = incdec_q;
        tmo_d    = tmo_q;

        case (state_q)
            ST_IDLE: begin
                done_d = 1'b1;
                if (load_i) begin
                    target_d = load_phase;
                    done_d   = 1'b0;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (load_i) begin
                    // Re-evaluate against the new target on the next cycle.
                    target_d = load_phase;
                end else if (cur_q == target_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    incdec_d = (target_q > cur_q);
                    psen_d   = 1'b1;
                    state_d  = ST_STEP;
                end
            end
            ST_STEP: begin
                if (load_i) begin
                    target_d = load_phase;
                end
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (dcm_psdone_i) begin
                    if (dcm_status_i[STATUS_PSOVF_BIT]) begin
                        target_d = cur_q;
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        cur_d   = incdec_q ? (cur_q + 9'sd1) : (cur_q - 9'sd1);
                        state_d = ST_CHECK;
                    end
                end else if (tmo_q == TW'(PSDONE_TIMEOUT - 1)) begin
                    target_d = cur_q;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                // A load that coincides with an abort still gets serviced.
                if (load_i) begin
                    target_d = load_phase;
                    done_d   = 1'b0;
                    if (state_d == ST_IDLE) begin
                        state_d = ST_CHECK;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cur_q    <= phase_t'(default_value_i);
            target_q <= phase_t'(default_value_i);
            done_q   <= 1'b1;
            psen_q   <= 1'b0;
            incdec_q <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            target_q <= target_d;
            done_q   <= done_d;
            psen_q   <= psen_d;
            incdec_q <= incdec_d;
            tmo_q    <= tmo_d;
        end
    end

    assign value_o        = cur_q;
    assign done_o         = done_q;
    assign dcm_psen_o     = psen_q;
    assign dcm_psincdec_o = incdec_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_dcm_phase_shift_interface.sv
// Directed bench for dcm_phase_shift_interface with a behavioural PSDONE responder.
module tb_dcm_phase_shift_interface;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [8:0] default_value_i;
  logic [8:0] value_i;
  logic       load_i;
  logic [8:0] value_o;
  logic       done_o;
  logic       dcm_psen_o;
  logic       dcm_psincdec_o;
  logic [7:0] dcm_status_i = 8'h00;
  logic       dcm_psdone_i = 1'b0;
  logic [1:0] state_o;

  int checks   = 0;
  int failures = 0;

  // Responder configuration and observation counters.
  int lat_cfg   = 3;
  bit drop      = 1'b0;
  int ovf_at    = -1;
  int pend      = 0;
  int psdone_n  = 0;
  int psen_n    = 0;
  int inc_n     = 0;
  int dec_n     = 0;
  int overlap_n = 0;

  dcm_phase_shift_interface #(.PSDONE_TIMEOUT(1023)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .default_value_i(default_value_i),
    .value_i        (value_i),
    .load_i         (load_i),
    .value_o        (value_o),
    .done_o         (done_o),
    .dcm_psen_o     (dcm_psen_o),
    .dcm_psincdec_o (dcm_psincdec_o),
    .dcm_status_i   (dcm_status_i),
    .dcm_psdone_i   (dcm_psdone_i),
    .state_o        (state_o)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // DCM model: acknowledges each psen pulse lat_cfg cycles later with a one-cycle psdone.
  always @(negedge clk) begin
    dcm_psdone_i = 1'b0;
    dcm_status_i = 8'h00;
    if (!reset_i) begin
      pend = 0;
    end else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          psdone_n++;
          dcm_psdone_i = 1'b1;
          if (psdone_n == ovf_at) dcm_status_i = 8'h01;
        end
      end
      if (dcm_psen_o) begin
        psen_n++;
        if (dcm_psincdec_o) inc_n++;
        else dec_n++;
        if (pend > 0) overlap_n++;
        if (!drop) pend = lat_cfg;
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(input int v);
    @(negedge clk);
    value_i = 9'(v);
    load_i  = 1'b1;
    @(negedge clk);
    load_i  = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag, output int n);
    n = 0;
    while (!(done_o === 1'b1 && state_o === 2'd0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, int'(n < budget), 1);
  endtask

  int p0, i0, d0, n;

  initial begin
    reset_i         = 1'b0;
    load_i          = 1'b0;
    value_i         = 9'd0;
    default_value_i = 9'd0;
    repeat (3) @(negedge clk);
    check("rst_value", $signed(value_o), 0);
    check("rst_done", int'(done_o), 1);
    check("rst_psen", int'(dcm_psen_o), 0);
    check("rst_state", int'(state_o), 0);

    // 1. Idle after release: nothing happens.
    reset_i = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_value", $signed(value_o), 0);
    check("idle_done", int'(done_o), 1);
    check("idle_psen_cnt", psen_n, 0);

    // 2. Shift up to +200.
    p0 = psen_n; i0 = inc_n;
    do_load(200);
    check("load_drops_done", int'(done_o), 0);
    wait_done(5000, "up200_timeout", n);
    check("up200_value", $signed(value_o), 200);
    check("up200_pulses", psen_n - p0, 200);
    check("up200_inc", inc_n - i0, 200);

    // 3. Down to 100, then to 0.
    p0 = psen_n; d0 = dec_n;
    do_load(100);
    wait_done(3000, "dn100_timeout", n);
    check("dn100_value", $signed(value_o), 100);
    check("dn100_pulses", psen_n - p0, 100);
    check("dn100_dec", dec_n - d0, 100);
    do_load(0);
    wait_done(3000, "dn0_timeout", n);
    check("dn0_value", $signed(value_o), 0);
    check("dn0_done", int'(done_o), 1);

    // 4. Reloading the current phase still pulses done low.
    do_load(5);
    wait_done(200, "to5_timeout", n);
    check("to5_value", $signed(value_o), 5);
    p0 = psen_n;
    do_load(5);
    check("same_done_low", int'(done_o), 0);
    @(negedge clk);
    check("same_done_high", int'(done_o), 1);
    check("same_no_pulse", psen_n - p0, 0);

    // Retarget mid-shift: 5 -> 20, redirected to 8.
    do_load(20);
    repeat (30) @(negedge clk);
    check("retarget_busy", int'(done_o), 0);
    do_load(8);
    wait_done(500, "retarget_timeout", n);
    check("retarget_value", $signed(value_o), 8);

    // 5. Overflow on the 4th acknowledge of a 0 -> 10 shift.
    do_load(0);
    wait_done(500, "ovf_prep_timeout", n);
    ovf_at = psdone_n + 4;
    p0 = psen_n;
    do_load(10);
    wait_done(500, "ovf_timeout", n);
    check("ovf_value", $signed(value_o), 3);
    check("ovf_pulses", psen_n - p0, 4);
    repeat (30) @(negedge clk);
    check("ovf_no_more", psen_n - p0, 4);
    check("ovf_done", int'(done_o), 1);
    ovf_at = -1;

    // 6. Dropped acknowledge: abort after exactly 1023 cycles in WAIT.
    drop = 1'b1;
    p0 = psen_n;
    do_load(50);
    wait_done(1500, "tmo_bound", n);
    check("tmo_cycles", n, 1025);
    check("tmo_value", $signed(value_o), 3);
    check("tmo_pulses", psen_n - p0, 1);
    drop = 1'b0;

    // Clamp: -256 loads as -255.
    p0 = psen_n;
    do_load(-256);
    wait_done(4000, "clamp_timeout", n);
    check("clamp_value", $signed(value_o), -255);
    check("clamp_pulses", psen_n - p0, 258);

    // Reset mid-shift while psen is high.
    do_load(100);
    repeat (50) @(negedge clk);
    n = 0;
    while (dcm_psen_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mid_psen_seen", int'(dcm_psen_o), 1);
    reset_i = 1'b0;
    #1;
    check("mid_rst_psen", int'(dcm_psen_o), 0);
    check("mid_rst_value", $signed(value_o), 0);
    check("mid_rst_done", int'(done_o), 1);
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
    p0 = psen_n;
    repeat (20) @(negedge clk);
    check("post_rst_state", int'(state_o), 0);
    check("post_rst_no_pulse", psen_n - p0, 0);
    check("overlap_count", overlap_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
